inst_mem_loader: RTL

//   Writer side of the instruction memory. The fetch path only reads it.

---
 rtl/inst_mem_loader_if.sv | 38 +++
 rtl/inst_mem_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the instruction memory loader.
// Latency: wiring only, no logic.
// Backpressure: in_valid/in_ready handshake on the byte stream; the RAM write port has none (always accepts).
//
// Signals:
//   in_valid  byte source -> loader   in_byte is valid
//   in_byte   byte source -> loader   stream byte
//   in_ready  loader -> byte source   loader accepts a byte this cycle
//   mem_we    loader -> RAM           one-cycle write strobe per word
//   mem_addr  loader -> RAM           word-aligned byte address
//   mem_data  loader -> RAM           packed big-endian word
// Modports: master = byte source / RAM side, slave = loader side.
interface inst_mem_loader_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    modport master (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_data
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Packs a byte stream big-endian into 32-bit words and writes them to instruction RAM from address 0, holding the CPU in reset meanwhile.
// Latency: a word is written one cycle after its 4th byte is accepted; done pulses the cycle after the last byte.
// Backpressure: in_ready is high only while loading (and in the checksum state); no internal buffering beyond one partial word.
//
// Ports:
//   clk, rst   single rising-edge clock, synchronous active-high reset
//   start      begin a load session (only looked at in IDLE)
//   length     number of words to load, clamped to 2**ADDR_W, zero is ignored
//   bus        slave side of inst_mem_loader_if (byte stream in, RAM write out)
//   cpu_hold   held high from the cycle after start up to and including done
//   done       one-cycle pulse at the end of a session
//   error      checksum mismatch, sticky until the next accepted start
// Optional feature macro INST_MEM_LOADER_CHECKSUM_EN: a trailing checksum byte is expected
// after the last word; error flags (byte sum + checksum) != 0. Without it error is tied low.
module inst_mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    inst_mem_loader_if.slave  bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CHK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    localparam state_t LOAD_EXIT = S_CHK;
`else
    localparam state_t LOAD_EXIT = S_DONE;
`endif

    state_t            state_q, state_nxt;
    logic              in_ready_q, in_ready_nxt;
    logic              cpu_hold_q, cpu_hold_nxt;
    logic              done_q, done_nxt;

    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   word_idx_q;
    logic [1:0]        byte_idx_q;
    logic [23:0]       shift_q;     // first three bytes of the word in flight, oldest in MSBs
    logic              mem_we_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_data_q;

    logic              accept;
    logic              start_ok;
    logic              word_end;
    logic              last_word;
    logic [ADDR_W:0]   len_clamped;

    assign accept      = bus.in_valid && in_ready_q;
    assign start_ok    = (state_q == S_IDLE) && start && (length != '0);
    assign word_end    = accept && (state_q == S_LOAD) && (byte_idx_q == 2'd3);
    assign last_word   = (word_idx_q == (len_q - ONE_WORD));
    // Any length with the top bit set is at least 2**ADDR_W, so it maps to the full RAM.
    assign len_clamped = length[ADDR_W] ? MAX_WORDS : length;

    // State and control-output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= in_ready_nxt;
            cpu_hold_q <= cpu_hold_nxt;
            done_q     <= done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: if (start_ok) state_nxt = S_LOAD;
            S_LOAD: if (word_end && last_word) state_nxt = LOAD_EXIT;
            S_CHK:  if (accept) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear as flops aligned with the state.
    always_comb begin
        in_ready_nxt = (state_nxt == S_LOAD) || (state_nxt == S_CHK);
        cpu_hold_nxt = (state_nxt != S_IDLE);
        done_nxt     = (state_nxt == S_DONE);
    end

    // Byte packing and RAM write port
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= 2'd0;
            shift_q    <= 24'd0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_data_q <= 32'd0;
        end else begin
            mem_we_q <= 1'b0;
            if (start_ok) begin
                len_q      <= len_clamped;
                word_idx_q <= '0;
                byte_idx_q <= 2'd0;
                shift_q    <= 24'd0;
            end else if (accept && (state_q == S_LOAD)) begin
                shift_q    <= {shift_q[15:0], bus.in_byte};
                byte_idx_q <= byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    mem_we_q   <= 1'b1;
                    mem_data_q <= {shift_q, bus.in_byte};
                    mem_addr_q <= {{(30 - ADDR_W){1'b0}}, word_idx_q[ADDR_W-1:0], 2'b00};
                    word_idx_q <= word_idx_q + ONE_WORD;
                end
            end
        end
    end

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= 8'd0;
            error_q <= 1'b0;
        end else if (start_ok) begin
            sum_q   <= 8'd0;
            error_q <= 1'b0;
        end else if (accept && (state_q == S_LOAD)) begin
            sum_q   <= sum_q + bus.in_byte;
        end else if (accept && (state_q == S_CHK)) begin
            // Lands in the same cycle as done because the CHK accept moves the FSM to DONE.
            error_q <= ((sum_q + bus.in_byte) != 8'h00);
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign bus.in_ready = in_ready_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;

endmodule
